// File: rtl/xt_dram_mp.sv
// xt_dram_mp: multi-port, word-interleaved local data RAM model.
// Up to two ports share a flat storage array. Same-bank collisions are
// arbitrated round-robin with a combinational Busy back-pressure signal.
// Each port has its own read pipeline of LATENCY register stages.

// Per-port read return pipeline: valid shift register plus data stages
// that only advance on valid, so the output holds its last read value.
module xt_dram_mp_rdpipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  rd_acc,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);
  logic [LATENCY:1]                 vld_q;
  logic [LATENCY:0]                 vld_pipe;
  logic [LATENCY:1][DATA_WIDTH-1:0] data_pipe;
  logic [LATENCY:0][DATA_WIDTH-1:0] dsrc;

  assign vld_pipe = {vld_q, rd_acc};
  assign dsrc     = {data_pipe, rd_data_in};

  // Shift valid every cycle; load a data stage only when its input is valid.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      vld_q     <= '0;
      data_pipe <= '0;
    end else begin
      for (int s = 1; s <= LATENCY; s++) begin
        vld_q[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= dsrc[s-1];
      end
    end
  end

  assign data_out  = data_pipe[LATENCY];
  assign valid_out = vld_pipe[LATENCY];
endmodule

module xt_dram_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 65536,
  parameter int AWIDTH     = 16,
  parameter int NPORTS     = 2,
  parameter int NBANKS     = 1,
  parameter int LATENCY    = 1
) (
  input  logic                                CLK,
  input  logic                                RESETN,
  input  logic [NPORTS*AWIDTH-1:0]            DRamAddr,
  input  logic [NPORTS-1:0]                   DRamEn,
  input  logic [NPORTS-1:0]                   DRamWr,
  input  logic [NPORTS*(DATA_WIDTH/8)-1:0]    DRamByteEn,
  input  logic [NPORTS*DATA_WIDTH-1:0]        DRamWrData,
  output logic [NPORTS-1:0]                   DRamBusy,
  output logic [NPORTS*DATA_WIDTH-1:0]        DRamData,
  output logic [NPORTS-1:0]                   DRamDataValid
);
  localparam int BYTES = DATA_WIDTH / 8;
  // Bank index is the low address bits; masking avoids a zero-width slice
  // when NBANKS = 1 (every pair of addresses then shares bank 0).
  localparam logic [AWIDTH-1:0] BANK_MASK = AWIDTH'(NBANKS - 1);

  typedef struct packed {
    logic                  wr;
    logic [AWIDTH-1:0]     addr;
    logic [BYTES-1:0]      be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [DATA_WIDTH-1:0] dataArray [DEPTH];

  logic [NPORTS-1:0][AWIDTH-1:0]     addr_v;
  logic [NPORTS-1:0][BYTES-1:0]      be_v;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] wd_v;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] rd_data;
  req_t [NPORTS-1:0]                 req;
  logic [NPORTS-1:0]                 busy, acc;
  logic                              conflict;
  logic                              ptr;

  assign addr_v = DRamAddr;
  assign be_v   = DRamByteEn;
  assign wd_v   = DRamWrData;

  // Bundle per-port request fields.
  always_comb begin
    req = '0;
    for (int p = 0; p < NPORTS; p++) begin
      req[p].wr    = DRamWr[p];
      req[p].addr  = addr_v[p];
      req[p].be    = be_v[p];
      req[p].wdata = wd_v[p];
    end
  end

  // Conflict only when two ports hit one bank; held low in reset so Busy is 0.
  if (NPORTS == 2) begin : g_two
    assign conflict = RESETN & DRamEn[0] & DRamEn[1] &
                      (((req[0].addr ^ req[1].addr) & BANK_MASK) == '0);
  end else begin : g_one
    assign conflict = 1'b0;
  end

  // Loser of a conflict is any port not named by the pointer.
  always_comb begin
    busy = '0;
    acc  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      busy[p] = conflict & (ptr != 1'(p));
      acc[p]  = RESETN & DRamEn[p] & ~busy[p];
    end
  end

  assign DRamBusy = busy;

  // Pointer hands priority to the loser, so only conflict cycles move it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)       ptr <= 1'b0;
    else if (conflict) ptr <= ~ptr;
  end

  // Byte-lane writes; storage is deliberately never reset.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < NPORTS; p++)
      for (int b = 0; b < BYTES; b++)
        if (acc[p] && req[p].wr && req[p].be[b])
          dataArray[req[p].addr][b*8 +: 8] <= req[p].wdata[b*8 +: 8];
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    xt_dram_mp_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_rdpipe (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .rd_acc    (acc[p] & ~req[p].wr),
      .rd_data_in(dataArray[req[p].addr]),
      .data_out  (rd_data[p]),
      .valid_out (DRamDataValid[p])
    );
  end

  assign DRamData = rd_data;
endmodule

// File: tb/tb_xt_dram_mp.sv
// Directed bench for xt_dram_mp: four instances cover LATENCY 1/2,
// one vs two banks, and a 128-bit single-port build.
module tb_xt_dram_mp;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Shared 32-bit two-port stimulus for instances a, b, c.
  logic [1:0]       en, wr;
  logic [1:0][9:0]  addr;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] wd;

  logic [1:0]       a_busy, a_vld, b_busy, b_vld, c_busy, c_vld;
  logic [1:0][31:0] a_data, b_data, c_data;

  logic         d_en, d_wr, d_busy, d_vld;
  logic [9:0]   d_addr;
  logic [15:0]  d_be;
  logic [127:0] d_wd, d_data;

  // a: 1 bank, latency 1
  xt_dram_mp #(.DATA_WIDTH(32), .DEPTH(1024), .AWIDTH(10), .NPORTS(2), .NBANKS(1), .LATENCY(1)) u_a (
    .CLK(clk), .RESETN(rst_n), .DRamAddr(addr), .DRamEn(en), .DRamWr(wr), .DRamByteEn(be),
    .DRamWrData(wd), .DRamBusy(a_busy), .DRamData(a_data), .DRamDataValid(a_vld));
  // b: 1 bank, latency 2
  xt_dram_mp #(.DATA_WIDTH(32), .DEPTH(1024), .AWIDTH(10), .NPORTS(2), .NBANKS(1), .LATENCY(2)) u_b (
    .CLK(clk), .RESETN(rst_n), .DRamAddr(addr), .DRamEn(en), .DRamWr(wr), .DRamByteEn(be),
    .DRamWrData(wd), .DRamBusy(b_busy), .DRamData(b_data), .DRamDataValid(b_vld));
  // c: 2 banks, latency 1
  xt_dram_mp #(.DATA_WIDTH(32), .DEPTH(1024), .AWIDTH(10), .NPORTS(2), .NBANKS(2), .LATENCY(1)) u_c (
    .CLK(clk), .RESETN(rst_n), .DRamAddr(addr), .DRamEn(en), .DRamWr(wr), .DRamByteEn(be),
    .DRamWrData(wd), .DRamBusy(c_busy), .DRamData(c_data), .DRamDataValid(c_vld));
  // d: 128-bit, single port, latency 1
  xt_dram_mp #(.DATA_WIDTH(128), .DEPTH(1024), .AWIDTH(10), .NPORTS(1), .NBANKS(1), .LATENCY(1)) u_d (
    .CLK(clk), .RESETN(rst_n), .DRamAddr(d_addr), .DRamEn(d_en), .DRamWr(d_wr), .DRamByteEn(d_be),
    .DRamWrData(d_wd), .DRamBusy(d_busy), .DRamData(d_data), .DRamDataValid(d_vld));

  task automatic test_reset();
    en = 2'b11; wr = 2'b00; addr = '0;
    #1;
    checks++; if (a_busy !== 2'b00 || b_busy !== 2'b00) begin errors++; $display("FAIL rst_busy got %b/%b want 00", a_busy, b_busy); end
    checks++; if (a_vld !== 2'b00 || b_vld !== 2'b00) begin errors++; $display("FAIL rst_valid got %b/%b want 00", a_vld, b_vld); end
    checks++; if (a_data !== '0 || b_data !== '0) begin errors++; $display("FAIL rst_data got %h/%h want 0", a_data, b_data); end
    @(negedge clk); en = 2'b00; rst_n = 1'b1;
    @(negedge clk); en = 2'b01; wr = 2'b00; addr[0] = 10'h040;
    @(negedge clk); en = 2'b00; rst_n = 1'b0;   // read in flight inside b
    #1;
    checks++; if (b_vld[0] !== 1'b0) begin errors++; $display("FAIL rst_flush_valid got %b want 0", b_vld[0]); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (b_vld[0] !== 1'b0 || b_data[0] !== 32'h0) begin errors++; $display("FAIL rst_release got vld %b data %h want 0/0", b_vld[0], b_data[0]); end
    end
  endtask

  task automatic test_byte_en();
    @(negedge clk); en = 2'b01; wr = 2'b01; addr[0] = 10'h010; be[0] = 4'hF; wd[0] = 32'h11223344;
    @(negedge clk); be[0] = 4'h5; wd[0] = 32'hAABBCCDD;
    @(negedge clk); wr = 2'b00; be[0] = 4'h0;
    @(negedge clk); en = 2'b00; #1;
    checks++; if (a_vld[0] !== 1'b1 || a_data[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be_l1 got vld %b data %h want 1/11bb33dd", a_vld[0], a_data[0]); end
    checks++; if (b_vld[0] !== 1'b0) begin errors++; $display("FAIL be_l2_early got %b want 0", b_vld[0]); end
    @(negedge clk); #1;
    checks++; if (a_vld[0] !== 1'b0 || a_data[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be_l1_hold got vld %b data %h want 0/11bb33dd", a_vld[0], a_data[0]); end
    checks++; if (b_vld[0] !== 1'b1 || b_data[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be_l2 got vld %b data %h want 1/11bb33dd", b_vld[0], b_data[0]); end
    @(negedge clk); #1;
    checks++; if (b_vld[0] !== 1'b0) begin errors++; $display("FAIL be_l2_once got %b want 0", b_vld[0]); end
    // ByteEn = 0 write changes nothing
    @(negedge clk); en = 2'b01; wr = 2'b01; be[0] = 4'h0; wd[0] = 32'hFFFFFFFF;
    @(negedge clk); wr = 2'b00;
    @(negedge clk); en = 2'b00; #1;
    checks++; if (a_vld[0] !== 1'b1 || a_data[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero got vld %b data %h want 1/11bb33dd", a_vld[0], a_data[0]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); en = 2'b01; wr = 2'b01; addr[0] = 10'(i); be[0] = 4'hF; wd[0] = 32'hC0DE0000 + i;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 8) begin en = 2'b01; wr = 2'b00; addr[0] = 10'(i); end
      else en = 2'b00;
      #1;
      checks++; if (b_busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_busy cycle %0d got %b want 0", i, b_busy[0]); end
      checks++; if (b_vld[0] !== (i >= 2 && i < 10)) begin errors++; $display("FAIL b2b_valid cycle %0d got %b want %b", i, b_vld[0], (i >= 2 && i < 10)); end
      if (b_vld[0]) begin
        checks++; if (b_data[0] !== 32'hC0DE0000 + beats) begin errors++; $display("FAIL b2b_data beat %0d got %h want %h", beats, b_data[0], 32'hC0DE0000 + beats); end
        beats++;
      end
    end
    checks++; if (beats != 8) begin errors++; $display("FAIL b2b_beats got %0d want 8", beats); end
  endtask

  task automatic test_conflict();
    @(negedge clk); en = 2'b01; wr = 2'b01; addr[0] = 10'h020; be[0] = 4'hF; wd[0] = 32'hA0A0A0A0;
    @(negedge clk); en = 2'b10; wr = 2'b10; addr[1] = 10'h021; be[1] = 4'hF; wd[1] = 32'hB1B1B1B1;
    @(negedge clk); en = 2'b11; wr = 2'b00; #1;
    checks++; if (a_busy !== 2'b10) begin errors++; $display("FAIL cf_busy0 got %b want 10", a_busy); end
    @(negedge clk); #1;
    checks++; if (a_busy !== 2'b01) begin errors++; $display("FAIL cf_busy1 got %b want 01", a_busy); end
    checks++; if (a_vld !== 2'b01 || a_data[0] !== 32'hA0A0A0A0) begin errors++; $display("FAIL cf_p0 got vld %b data %h want 01/a0a0a0a0", a_vld, a_data[0]); end
    @(negedge clk); en = 2'b00; #1;
    checks++; if (a_vld !== 2'b10 || a_data[1] !== 32'hB1B1B1B1) begin errors++; $display("FAIL cf_p1 got vld %b data %h want 10/b1b1b1b1", a_vld, a_data[1]); end
    @(negedge clk); en = 2'b11; #1;
    checks++; if (a_busy !== 2'b10) begin errors++; $display("FAIL cf_busy2 got %b want 10", a_busy); end
    @(negedge clk); en = 2'b00; #1;
    checks++; if (a_vld !== 2'b01) begin errors++; $display("FAIL cf_p0b got vld %b want 01", a_vld); end
    @(negedge clk);
  endtask

  task automatic test_no_conflict();
    int n0 = 0, n1 = 0;
    @(negedge clk); en = 2'b01; wr = 2'b01; addr[0] = 10'h002; be[0] = 4'hF; wd[0] = 32'h22222222;
    @(negedge clk); en = 2'b10; wr = 2'b10; addr[1] = 10'h003; be[1] = 4'hF; wd[1] = 32'h33333333;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 16) begin en = 2'b11; wr = 2'b00; end
      else en = 2'b00;
      #1;
      checks++; if (c_busy !== 2'b00) begin errors++; $display("FAIL nc_busy cycle %0d got %b want 00", i, c_busy); end
      if (i == 0) begin
        // single-bank instance still arbitrates; its pointer favours P1 here
        checks++; if (a_busy !== 2'b01) begin errors++; $display("FAIL nc_onebank got %b want 01", a_busy); end
      end
      if (c_vld[0]) begin
        n0++;
        checks++; if (c_data[0] !== 32'h22222222) begin errors++; $display("FAIL nc_d0 got %h want 22222222", c_data[0]); end
      end
      if (c_vld[1]) begin
        n1++;
        checks++; if (c_data[1] !== 32'h33333333) begin errors++; $display("FAIL nc_d1 got %h want 33333333", c_data[1]); end
      end
    end
    checks++; if (n0 != 16 || n1 != 16) begin errors++; $display("FAIL nc_beats got %0d/%0d want 16/16", n0, n1); end
  endtask

  task automatic test_wide();
    @(negedge clk); d_en = 1'b1; d_wr = 1'b1; d_addr = 10'h005; d_be = 16'hFFFF;
    d_wd = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    @(negedge clk); d_be = 16'h8001; d_wd = {16{8'hA5}};
    @(negedge clk); d_wr = 1'b0;
    @(negedge clk); d_en = 1'b0; #1;
    checks++; if (d_busy !== 1'b0 || d_vld !== 1'b1) begin errors++; $display("FAIL wide_vld got busy %b vld %b want 0/1", d_busy, d_vld); end
    checks++; if (d_data !== 128'hA5112233_44556677_8899AABB_CCDDEEA5) begin errors++; $display("FAIL wide_data got %h want a5112233445566778899aabbccddeea5", d_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0; wr = '0; addr = '0; be = '0; wd = '0;
    d_en = 1'b0; d_wr = 1'b0; d_addr = '0; d_be = '0; d_wd = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_byte_en();
    test_back_to_back();
    test_conflict();
    test_no_conflict();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
